pll_dyncfg_ctrl: RTL and testbench

//  Sequencer for the PLL dynamic-setting shift register (27-bit serial config: PLL_SCK/PLL_SDI/PLL_SDO, RESETB).

---
 rtl/pll_dyncfg_pkg.sv | 42 ++++
 rtl/pll_sck_gen.sv | 39 +++
 rtl/pll_dyncfg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pll_dyncfg_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_dyncfg_pkg.sv
// pll_dyncfg_pkg: shared types, states and config-word layout for the PLL dynamic-setting sequencer
package pll_dyncfg_pkg;

    localparam int CFG_W = 27;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ASSERT_RST = 3'd1;
    localparam state_t ST_SHIFT      = 3'd2;
    localparam state_t ST_SETTLE     = 3'd3;
    localparam state_t ST_WAIT_LOCK  = 3'd4;
    localparam state_t ST_LOCKED     = 3'd5;
    localparam state_t ST_FAIL       = 3'd6;

    localparam int DIVR_LSB       = 0;
    localparam int DIVF_LSB       = 4;
    localparam int DIVQ_LSB       = 11;
    localparam int RANGE_LSB      = 14;
    localparam int DELAYSEL_LSB   = 17;
    localparam int OUT2SEL_LSB    = 19;
    localparam int DIVMODE_LO_BIT = 21;
    localparam int REFSEL_BIT     = 22;
    localparam int OUT1SEL_LSB    = 23;
    localparam int FSE_BIT        = 25;
    localparam int DIVMODE_HI_BIT = 26;

    typedef struct packed {
        logic       divmode_hi;
        logic       fse;
        logic [1:0] out1sel;
        logic       refsel;
        logic       divmode_lo;
        logic [1:0] out2sel;
        logic [1:0] delaysel;
        logic [2:0] range_sel;
        logic [2:0] divq;
        logic [6:0] divf;
        logic [3:0] divr;
    } pll_cfg_t;

endpackage

// File: rtl/pll_sck_gen.sv
// pll_sck_gen: serial clock generator with per-bit rise/fall strobes, idle low when disabled
module pll_sck_gen #(
    parameter int unsigned SCK_HALF = 4
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic en_i,
    output logic sck_o,
    output logic bit_strobe_rise_o,
    output logic bit_strobe_fall_o
);

    localparam int unsigned CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic sck_q, sck_d, wrap;

    always_comb begin
        wrap = en_i && (cnt_q == LAST);
        bit_strobe_rise_o = wrap && !sck_q;
        bit_strobe_fall_o = wrap && sck_q;
        cnt_d = (!en_i || wrap) ? '0 : cnt_q + CW'(1);
        sck_d = en_i && (sck_q ^ wrap);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/pll_dyncfg_ctrl.sv
// pll_dyncfg_ctrl: loads the PLL serial config under reset, releases it and supervises lock with retries
module pll_dyncfg_ctrl
    import pll_dyncfg_pkg::*;
#(
    parameter int unsigned SCK_HALF     = 4,
    parameter int unsigned RST_SETUP    = 4,
    parameter int unsigned RELEASE_WAIT = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CFG_W-1:0] cfg_data_i,
    output logic [CFG_W-1:0] prev_cfg_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             lock_lost_o,
    output logic             locked_o,
    output logic             pll_sck_o,
    output logic             pll_sdi_o,
    input  logic             pll_sdo_i,
    output logic             pll_resetb_o,
    input  logic             pll_lock_i
);

    localparam logic [15:0] SETUP_LAST   = 16'(RST_SETUP - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(RELEASE_WAIT - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRY);

    state_t state_q, state_d;
    pll_cfg_t cfg_q, cfg_d;
    logic [CFG_W-1:0] shift_q, shift_d, prev_q, prev_d;
    logic [4:0] bit_q, bit_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0] retry_q, retry_d;
    logic resetb_q, resetb_d, done_q, done_d, error_q, error_d, lost_q, lost_d;
    logic lock_m_q, lock_s_q;
    logic sck, rise, fall, idle;

    assign idle = state_q inside {ST_IDLE, ST_LOCKED, ST_FAIL};

    pll_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
        .clk_i             (clk_i),
        .resetn_i          (resetn_i),
        .en_i              (state_q == ST_SHIFT),
        .sck_o             (sck),
        .bit_strobe_rise_o (rise),
        .bit_strobe_fall_o (fall)
    );

    always_comb begin
        state_d = state_q;
        cfg_d = cfg_q;
        shift_d = shift_q;
        prev_d = prev_q;
        bit_d = bit_q;
        timer_d = timer_q;
        retry_d = retry_q;
        resetb_d = resetb_q;
        done_d = 1'b0;
        error_d = 1'b0;
        lost_d = 1'b0;
        if (idle && cfg_valid_i) begin
            cfg_d = cfg_data_i;
            retry_d = '0;
            resetb_d = 1'b0;
            timer_d = '0;
            state_d = ST_ASSERT_RST;
        end else begin
            case (state_q)
                ST_ASSERT_RST: begin
                    bit_d = 5'(CFG_W - 1);
                    timer_d = (timer_q == SETUP_LAST) ? '0 : timer_q + 16'd1;
                    state_d = (timer_q == SETUP_LAST) ? ST_SHIFT : state_q;
                end
                ST_SHIFT: begin
                    // SDO is sampled just before the rising edge clocks the PLL register
                    if (rise) shift_d[bit_q] = pll_sdo_i;
                    if (fall && bit_q == 5'd0) begin
                        prev_d = shift_q;
                        state_d = ST_SETTLE;
                    end else if (fall) begin
                        bit_d = bit_q - 5'd1;
                    end
                end
                ST_SETTLE: begin
                    resetb_d = (timer_q == SETTLE_LAST);
                    timer_d = (timer_q == SETTLE_LAST) ? '0 : timer_q + 16'd1;
                    state_d = (timer_q == SETTLE_LAST) ? ST_WAIT_LOCK : state_q;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_LOCKED;
                        done_d = 1'b1;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        resetb_d = 1'b0;
                        timer_d = '0;
                        retry_d = (retry_q < RETRY_MAX) ? retry_q + 3'd1 : retry_q;
                        error_d = (retry_q >= RETRY_MAX);
                        state_d = (retry_q < RETRY_MAX) ? ST_ASSERT_RST : ST_FAIL;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s_q) begin
                        lost_d = 1'b1;
                        timer_d = '0;
                        retry_d = '0;
                        state_d = ST_WAIT_LOCK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            cfg_q <= '0;
            shift_q <= '0;
            prev_q <= '0;
            bit_q <= '0;
            timer_q <= '0;
            retry_q <= '0;
            resetb_q <= 1'b0;
            done_q <= 1'b0;
            error_q <= 1'b0;
            lost_q <= 1'b0;
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q <= cfg_d;
            shift_q <= shift_d;
            prev_q <= prev_d;
            bit_q <= bit_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            resetb_q <= resetb_d;
            done_q <= done_d;
            error_q <= error_d;
            lost_q <= lost_d;
            lock_m_q <= pll_lock_i;
            lock_s_q <= lock_m_q;
        end
    end

    assign cfg_ready_o = idle;
    assign busy_o = !idle;
    assign done_o = done_q;
    assign error_o = error_q;
    assign lock_lost_o = lost_q;
    assign locked_o = (state_q == ST_LOCKED);
    assign prev_cfg_o = prev_q;
    assign pll_sck_o = sck;
    assign pll_sdi_o = (state_q == ST_SHIFT) && cfg_q[bit_q];
    assign pll_resetb_o = resetb_q;

endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// tb_pll_dyncfg_ctrl: directed scenarios against a shift-register PLL model with controllable lock
module tb_pll_dyncfg_ctrl;

    localparam int SCK_HALF     = 4;
    localparam int RST_SETUP    = 4;
    localparam int RELEASE_WAIT = 16;
    localparam int LOCK_TIMEOUT = 100;
    localparam int MAX_RETRY    = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic cfg_valid = 1'b0;
    logic [26:0] cfg_data = '0;
    logic cfg_ready, busy, done, error, lock_lost, locked;
    logic [26:0] prev_cfg;
    logic pll_sck, pll_sdi, pll_sdo, pll_resetb, pll_lock;

    logic [26:0] pll_sr = 27'h0123456;
    bit lock_mode = 0, drop = 0, lock_force = 0;
    int lock_cnt = 0;

    int passed = 0, total = 0;
    int cyc = 0, n_rise = 0, n_done = 0, n_lost = 0, n_rb_rise = 0, viol = 0;
    int t_busy = 0, t_first = 0, t_fall = 0, t_rb_rise = 0, t_rb_fall = 0;
    bit armed = 0;
    logic sck_p = 1'b0, rb_p = 1'b0, busy_p = 1'b0;

    logic [26:0] w2 = 27'h3C0FF0F, w3 = 27'h1111111, w4 = 27'h0ABCDEF;
    logic [26:0] w5 = 27'h6DB6DB6, w6 = 27'h2468ACE, w7 = 27'h7531ECA;

    pll_dyncfg_ctrl #(
        .SCK_HALF     (SCK_HALF),
        .RST_SETUP    (RST_SETUP),
        .RELEASE_WAIT (RELEASE_WAIT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_data_i   (cfg_data),
        .prev_cfg_o   (prev_cfg),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .lock_lost_o  (lock_lost),
        .locked_o     (locked),
        .pll_sck_o    (pll_sck),
        .pll_sdi_o    (pll_sdi),
        .pll_sdo_i    (pll_sdo),
        .pll_resetb_o (pll_resetb),
        .pll_lock_i   (pll_lock)
    );

    always #5 clk = ~clk;

    assign pll_sdo = pll_sr[26];
    assign pll_lock = (lock_mode && lock_cnt >= 10 && !drop) || lock_force;

    always @(posedge pll_sck) pll_sr <= {pll_sr[25:0], pll_sdi};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        lock_cnt <= pll_resetb ? lock_cnt + 1 : 0;
        sck_p <= pll_sck;
        rb_p <= pll_resetb;
        busy_p <= busy;
        if (busy && !busy_p) begin
            t_busy <= cyc;
            armed <= 1;
        end
        if (pll_sck && !sck_p) begin
            n_rise <= n_rise + 1;
            if (armed) begin
                t_first <= cyc;
                armed <= 0;
            end
        end
        if (!pll_sck && sck_p) t_fall <= cyc;
        if (pll_resetb && !rb_p) begin
            t_rb_rise <= cyc;
            n_rb_rise <= n_rb_rise + 1;
        end
        if (!pll_resetb && rb_p) t_rb_fall <= cyc;
        if (pll_sck !== sck_p && pll_resetb) viol <= viol + 1;
        n_done <= n_done + int'(done);
        n_lost <= n_lost + int'(lock_lost);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [26:0] w);
        cfg_data = w;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_evt(input bit want_err, input int max, output bit seen);
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            seen = want_err ? error : done;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        total++;
        if ({cfg_ready, busy, done, error, lock_lost, locked, pll_sck, pll_sdi, pll_resetb} !== 9'b100000000)
            $display("FAIL reset_outs: got %b want 100000000", {cfg_ready, busy, done, error, lock_lost, locked, pll_sck, pll_sdi, pll_resetb});
        else passed++;
        total++;
        if (prev_cfg !== 27'h0) $display("FAIL reset_prev_cfg: got %h want 0", prev_cfg);
        else passed++;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_load();
        int r0;
        bit seen;
        lock_mode = 1;
        r0 = n_rise;
        load(27'h5A5A5A5);
        total++;
        if ({busy, cfg_ready, pll_resetb} !== 3'b100) $display("FAIL accept: got %b want 100", {busy, cfg_ready, pll_resetb});
        else passed++;
        wait_evt(0, 2000, seen);
        total++;
        if (seen !== 1) $display("FAIL load_done: got %0d want 1", seen);
        else passed++;
        total++;
        if (n_rise - r0 !== 27) $display("FAIL load_sck_count: got %0d want 27", n_rise - r0);
        else passed++;
        total++;
        if (pll_sr !== 27'h5A5A5A5) $display("FAIL sdi_msb_first: got %h want 5a5a5a5", pll_sr);
        else passed++;
        total++;
        if (prev_cfg !== 27'h0123456) $display("FAIL prev_cfg: got %h want 0123456", prev_cfg);
        else passed++;
        total++;
        if ({locked, busy, cfg_ready} !== 3'b101) $display("FAIL locked_state: got %b want 101", {locked, busy, cfg_ready});
        else passed++;
        total++;
        if (t_first - t_busy < RST_SETUP) $display("FAIL rst_setup: got %0d want >=%0d", t_first - t_busy, RST_SETUP);
        else passed++;
        total++;
        if (t_fall - t_first + SCK_HALF !== 216) $display("FAIL shift_len: got %0d want 216", t_fall - t_first + SCK_HALF);
        else passed++;
        total++;
        if (t_rb_rise - t_fall !== RELEASE_WAIT) $display("FAIL release_wait: got %0d want %0d", t_rb_rise - t_fall, RELEASE_WAIT);
        else passed++;
        step();
        total++;
        if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done);
        else passed++;
    endtask

    task automatic test_lock_loss();
        int r0, l0;
        bit seen;
        r0 = n_rise;
        l0 = n_lost;
        drop = 1;
        repeat (4) step();
        total++;
        if (locked !== 1'b0) $display("FAIL lock_drop_locked: got %b want 0", locked);
        else passed++;
        step();
        drop = 0;
        wait_evt(0, 50, seen);
        total++;
        if (seen !== 1) $display("FAIL relock_done: got %0d want 1", seen);
        else passed++;
        total++;
        if (n_lost - l0 !== 1) $display("FAIL lock_lost_count: got %0d want 1", n_lost - l0);
        else passed++;
        total++;
        if (n_rise !== r0) $display("FAIL relock_no_sck: got %0d want %0d", n_rise, r0);
        else passed++;
        total++;
        if ({locked, pll_resetb} !== 2'b11) $display("FAIL relock_state: got %b want 11", {locked, pll_resetb});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int r0;
        bit seen, bad;
        r0 = n_rise;
        bad = 0;
        cfg_data = w2;
        cfg_valid = 1'b1;
        step();
        cfg_data = w3;
        repeat (100) begin
            step();
            if (cfg_ready !== 1'b0 || busy !== 1'b1) bad = 1;
        end
        cfg_valid = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL ready_low_while_busy: got %0d want 0", bad);
        else passed++;
        wait_evt(0, 2000, seen);
        total++;
        if (seen !== 1) $display("FAIL b2b_done: got %0d want 1", seen);
        else passed++;
        total++;
        if (n_rise - r0 !== 27) $display("FAIL b2b_sck_count: got %0d want 27", n_rise - r0);
        else passed++;
        total++;
        if (pll_sr !== w2) $display("FAIL b2b_word: got %h want %h", pll_sr, w2);
        else passed++;
        total++;
        if (prev_cfg !== 27'h5A5A5A5) $display("FAIL b2b_prev: got %h want 5a5a5a5", prev_cfg);
        else passed++;
    endtask

    task automatic test_retry();
        int r0, b0, d0;
        bit seen;
        lock_mode = 0;
        r0 = n_rise;
        b0 = n_rb_rise;
        d0 = n_done;
        load(w4);
        wait_evt(1, 3000, seen);
        total++;
        if (seen !== 1) $display("FAIL fail_error: got %0d want 1", seen);
        else passed++;
        total++;
        if (n_rise - r0 !== 27 * (MAX_RETRY + 1)) $display("FAIL retry_sck_count: got %0d want %0d", n_rise - r0, 27 * (MAX_RETRY + 1));
        else passed++;
        total++;
        if (n_rb_rise - b0 !== MAX_RETRY + 1) $display("FAIL retry_releases: got %0d want %0d", n_rb_rise - b0, MAX_RETRY + 1);
        else passed++;
        total++;
        if (t_rb_fall - t_rb_rise !== LOCK_TIMEOUT) $display("FAIL lock_timeout: got %0d want %0d", t_rb_fall - t_rb_rise, LOCK_TIMEOUT);
        else passed++;
        total++;
        if (n_done !== d0) $display("FAIL retry_no_done: got %0d want %0d", n_done, d0);
        else passed++;
        total++;
        if ({cfg_ready, busy, locked, pll_resetb} !== 4'b1000) $display("FAIL fail_state: got %b want 1000", {cfg_ready, busy, locked, pll_resetb});
        else passed++;
        total++;
        if (prev_cfg !== w4) $display("FAIL retry_prev: got %h want %h", prev_cfg, w4);
        else passed++;
        step();
        total++;
        if (error !== 1'b0) $display("FAIL error_width: got %b want 0", error);
        else passed++;
    endtask

    task automatic test_tie();
        int r0;
        bit seen, rb;
        r0 = n_rise;
        load(w5);
        rb = 0;
        for (int i = 0; i < 400 && !rb; i++) begin
            step();
            rb = pll_resetb;
        end
        total++;
        if (rb !== 1) $display("FAIL tie_release: got %0d want 1", rb);
        else passed++;
        repeat (LOCK_TIMEOUT - 3) step();
        lock_force = 1;
        wait_evt(0, 10, seen);
        total++;
        if (seen !== 1) $display("FAIL tie_lock_wins: got %0d want 1", seen);
        else passed++;
        total++;
        if ({locked, pll_resetb} !== 2'b11) $display("FAIL tie_state: got %b want 11", {locked, pll_resetb});
        else passed++;
        total++;
        if (n_rise - r0 !== 27) $display("FAIL tie_sck_count: got %0d want 27", n_rise - r0);
        else passed++;
    endtask

    task automatic test_reset_midshift();
        int r0;
        bit seen, hit;
        logic [26:0] exp_prev;
        exp_prev = {w5[12:0], w6[26:13]};
        lock_mode = 1;
        lock_force = 0;
        r0 = n_rise;
        load(w6);
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step();
            hit = (n_rise - r0 == 14);
        end
        total++;
        if (hit !== 1) $display("FAIL mid_reach_bit13: got %0d want 1", hit);
        else passed++;
        resetn = 1'b0;
        #1;
        total++;
        if ({cfg_ready, busy, done, error, lock_lost, locked, pll_sck, pll_sdi, pll_resetb} !== 9'b100000000)
            $display("FAIL mid_reset_outs: got %b want 100000000", {cfg_ready, busy, done, error, lock_lost, locked, pll_sck, pll_sdi, pll_resetb});
        else passed++;
        total++;
        if (prev_cfg !== 27'h0) $display("FAIL mid_reset_prev: got %h want 0", prev_cfg);
        else passed++;
        step();
        resetn = 1'b1;
        step();
        r0 = n_rise;
        load(w7);
        wait_evt(0, 2000, seen);
        total++;
        if (seen !== 1) $display("FAIL reload_done: got %0d want 1", seen);
        else passed++;
        total++;
        if (n_rise - r0 !== 27) $display("FAIL reload_sck_count: got %0d want 27", n_rise - r0);
        else passed++;
        total++;
        if (pll_sr !== w7) $display("FAIL reload_word: got %h want %h", pll_sr, w7);
        else passed++;
        total++;
        if (prev_cfg !== exp_prev) $display("FAIL reload_prev: got %h want %h", prev_cfg, exp_prev);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_lock_loss();
        test_back_to_back();
        test_retry();
        test_tie();
        test_reset_midshift();
        total++;
        if (viol !== 0) $display("FAIL sck_while_released: got %0d want 0", viol);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
